// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited in-order imem requests, {pc, instr} FIFO to decode.
// Head is visible the cycle after a live response; issue stalls when buffer credit runs out. Option: MISALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          run_q, run_d;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_in;
  logic          rsp_drop;
  logic          enq;
  logic          deq;

  // Credit counts live in-flight words plus buffered words, so a live response always finds a free slot.
  assign credit_used = ({1'b0, out_cnt_q} - {1'b0, disc_cnt_q}) + {1'b0, count_q};

  assign imem_req_valid_o = run_q && !redirect_i && (out_cnt_q < CW'(DEPTH))
                            && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  // Responses with nothing outstanding belong to requests issued before a reset.
  assign rsp_in   = imem_rsp_valid_i && (out_cnt_q != '0);
  assign rsp_drop = rsp_in && (disc_cnt_q != '0);
  assign enq      = rsp_in && !rsp_drop && !redirect_i;
  assign deq      = instr_valid_o && instr_ready_i;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_q[rd_ptr_q].instr : '0;
  assign pc_o          = instr_valid_o ? fifo_q[rd_ptr_q].pc : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_cnt_d = disc_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;
    run_d      = 1'b1;
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_in);

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      rsp_pc_d   = redirect_pc_i & ~32'h3;
      disc_cnt_d = out_cnt_q - CW'(rsp_in);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) disc_cnt_d = disc_cnt_q - CW'(1);
      if (enq) begin
        fifo_d[wr_ptr_q] = entry_t'{pc: rsp_pc_q, instr: imem_rsp_data_i};
        wr_ptr_d         = wr_ptr_q + PW'(1);
        rsp_pc_d         = rsp_pc_q + 32'd4;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      run_q      <= run_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(enq && (count_q == CW'(DEPTH))));
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q | (redirect_i && (redirect_pc_i[1:0] != 2'b00));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: imem model with variable latency, expected PCs queued at request acceptance.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o)
`ifdef MISALIGN_CHECK_EN
    ,
    .misalign_o       (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rdy_rand = 1'b0;
  bit          cons = 1'b1;
  int          deqs = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] model_pc = RST_PC;
  logic [31:0] mq_addr [$];
  int          mq_due [$];
  logic [31:0] exp_pc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at negedge, observe settled outputs, update memory and scoreboard.
  task automatic step(input bit redir, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    imem_req_ready_i = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    instr_ready_i    = cons;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_data(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
    end
    #1;
    if (prev_stall && !redir) begin
      check("req_hold_vld", 32'(imem_req_valid_o), 32'd1);
      check("req_hold_addr", imem_req_addr_o, prev_addr);
    end
    prev_stall = imem_req_valid_o && !imem_req_ready_i;
    prev_addr  = imem_req_addr_o;
    if (redir) check("redir_no_req", 32'(imem_req_valid_o), 32'd0);
    if (instr_valid_o && instr_ready_i) begin
      deqs++;
      if (exp_pc.size() == 0) begin
        check("sb_empty_deq", 32'(instr_valid_o), 32'd0);
      end else begin
        e = exp_pc.pop_front();
        check("pc", pc_o, e);
        check("instr", instr_o, mem_data(e));
      end
    end
    if (redir) begin
      exp_pc.delete();
      model_pc = rpc & ~32'h3;
    end else if (imem_req_valid_o && imem_req_ready_i) begin
      check("req_addr", imem_req_addr_o, model_pc);
      exp_pc.push_back(model_pc);
      mq_addr.push_back(imem_req_addr_o);
      mq_due.push_back(cyc + lat);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i            = 1'b1;
    redirect_i       = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    instr_ready_i    = 1'b0;
    repeat (2) @(negedge clk);
    mq_addr.delete();
    mq_due.delete();
    exp_pc.delete();
    model_pc   = RST_PC;
    prev_stall = 1'b0;
    rst_i      = 1'b0;
    #1;
    check("rst_req_vld", 32'(imem_req_valid_o), 32'd0);
    check("rst_instr_vld", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
`ifdef MISALIGN_CHECK_EN
    check("rst_misalign", 32'(misalign_o), 32'd0);
`endif
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      step(1'b0, 32'h0);
      n++;
    end while (!instr_valid_o && n < 40);
    if (!instr_valid_o) check(tag, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    int n;
    int d0;

    do_reset();

    // Fill from a reset PC that wraps through zero, then measure sustained rate.
    cons = 1'b1;
    wait_valid("to_first", n);
    check("first_pc", pc_o, RST_PC);
    d0 = deqs;
    repeat (12) step(1'b0, 32'h0);
    check("throughput", 32'(deqs - d0), 32'd12);

    // Decode stall: buffer saturates at DEPTH, no request issue, nothing in flight.
    cons = 1'b0;
    repeat (10) step(1'b0, 32'h0);
    check("stall_req_vld", 32'(imem_req_valid_o), 32'd0);
    check("stall_instr_vld", 32'(instr_valid_o), 32'd1);
    check("stall_held", 32'(exp_pc.size()), 32'(DEPTH));
    check("stall_inflight", 32'(mq_addr.size()), 32'd0);
    cons = 1'b1;
    repeat (10) step(1'b0, 32'h0);

    // Memory request backpressure.
    rdy_rand = 1'b1;
    repeat (40) step(1'b0, 32'h0);
    rdy_rand = 1'b0;
    repeat (6) step(1'b0, 32'h0);

    // Redirect with several requests outstanding at latency 3.
    lat = 3;
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    wait_valid("to_redir3", n);
    check("redir3_pc", pc_o, 32'h0000_0100);
    repeat (10) step(1'b0, 32'h0);

    // Redirect coinciding with a response and a dequeue, to a misaligned target.
    lat = 1;
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0102);
    step(1'b0, 32'h0);
    check("flush_empty", 32'(instr_valid_o), 32'd0);
    wait_valid("to_redir1", n);
    check("redir_lat", 32'(n + 1), 32'd3);
    check("redir1_pc", pc_o, 32'h0000_0100);
`ifdef MISALIGN_CHECK_EN
    check("misalign_set", 32'(misalign_o), 32'd1);
`endif
    repeat (10) step(1'b0, 32'h0);

    // Reset in the middle of streaming.
    do_reset();
    wait_valid("to_after_rst", n);
    check("rst_resume_pc", pc_o, RST_PC);
    repeat (8) step(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end of the pipeline.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO and hands {pc, instruction} to the decode stage through a valid/ready handshake. Decode feeds the instruction to the immediate generator.
- On a branch/jump redirect from execute, it flushes the buffer and discards in-flight responses.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of 2, at least 2.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request this cycle.
- imem_req_addr_o  output  32  request byte address, always word aligned.
- imem_rsp_valid_i  input  1  response word valid; in order, at least 1 cycle after acceptance, no backpressure.
- imem_rsp_data_i  input  32  response instruction word.
- redirect_i  input  1  flush and restart fetch.
- redirect_pc_i  input  32  new fetch PC.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  decode consumes head.
- instr_o  output  32  head instruction.
- pc_o  output  32  head instruction PC.

Behaviour:
Reset (rst_i high at a clock edge):
- fetch_pc <= RESET_PC; rsp_pc <= RESET_PC.
- FIFO count, out_cnt and disc_cnt <= 0.
- imem_req_valid_o = 0 and instr_valid_o = 0 in the first cycle after reset.
- instr_o and pc_o = 0 while empty.
- Reset mid-operation drops all buffered words; responses still in flight afterwards are ignored.

State:
- fetch_pc: next request address.
- rsp_pc: PC of the next live response.
- out_cnt: all in-flight requests, 0..DEPTH.
- disc_cnt: in-flight requests to be discarded, 0..out_cnt.
- FIFO: DEPTH entries of {pc, instr} with wrap-around read and write pointers and a count.

Issue:
- imem_req_valid_o = !redirect_i && out_cnt < DEPTH && (out_cnt - disc_cnt) + count < DEPTH.
- Uses registered values only; a same-cycle dequeue does not free credit.
- imem_req_addr_o = fetch_pc.
- On valid && ready: fetch_pc += 4 (mod 2^32, wraps 0xFFFFFFFC -> 0), out_cnt += 1.
- The request is held stable until accepted.

Response:
- Every imem_rsp_valid_i decrements out_cnt.
- If disc_cnt > 0, the response is dropped and disc_cnt -= 1.
- Otherwise {rsp_pc, data} is written to the FIFO and rsp_pc += 4.
- The credit rule guarantees the FIFO is never full when a live response arrives. Overflow is impossible and must not be handled silently.

Dequeue:
- instr_valid_o = count != 0.
- On valid && ready, the read pointer advances.
- Enqueue and dequeue in the same cycle leave count unchanged and pass the data correctly, including at pointer wrap.
- Full plus dequeue with no enqueue gives count = DEPTH-1.

Redirect (redirect_i = 1), which has priority over everything except reset. At that edge:
- The FIFO is emptied, including any same-cycle dequeue or enqueue.
- fetch_pc <= redirect_pc_i & ~3 and rsp_pc <= the same value.
- disc_cnt <= out_cnt minus 1 if a response arrives this cycle; that response is itself dropped.
- No request is issued in the redirect cycle.
- The first new request is presented the next cycle.
- A second redirect while discards are pending adds nothing to disc_cnt beyond the requests actually in flight.

Latency and throughput:
- With 1-cycle memory latency, the redirect target is on instr_o 3 cycles after the redirect edge.
- With DEPTH=4 and no stalls, throughput is sustained at 1 instruction/cycle.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- With it:
  - An extra output, misalign_o (1 bit, reset 0), is added.
  - It is set sticky when redirect_i is high with redirect_pc_i[1:0] != 0.
  - It is cleared only by rst_i.
  - The redirect is still taken to the aligned address.
- Without it: no port; low address bits are silently masked.

Test Plan:
- Reset, imem 1-cycle latency returning addr-derived data, instr_ready_i=1 -> pc_o sequence 0x0,0x4,0x8,... with one instruction per cycle once filled; instr_o matches memory.
- Hold instr_ready_i=0 for 10 cycles -> count saturates at 4, imem_req_valid_o stays low, no word lost or duplicated after release.
- imem_req_ready_i toggled 0/1 pseudo-randomly -> imem_req_addr_o held stable while stalled, in-order PCs out.
- Redirect to 0x00000100 with 3 requests outstanding and memory latency 3 -> the 3 stale responses are dropped; the next instr_valid_o shows pc_o=0x100.
- Redirect coincident with a response and a dequeue -> FIFO empty the next cycle, stale word never appears, fetch resumes at the target.
- RESET_PC=32'hFFFFFFF8, run 4 fetches -> PCs FFFFFFF8, FFFFFFFC, 00000000, 00000004. With MISALIGN_CHECK_EN, redirect to 0x102 -> misalign_o=1 and pc_o=0x100.
